imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage of the pipelined CPU. It decodes all five RISC-V immediate formats (I, S, B, U, J) to a sign-extended XLEN-bit value and classifies the format. Unrecognised opcodes are flagged as illegal. A valid/ready handshake on both sides, backed by a 2-entry skid buffer, lets fetch and execute stall independently without dropping or duplicating instructions.

---
 rtl/imm_gen_pipe.sv | 135 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RISC-V immediate decoder with a valid/ready 2-entry skid buffer
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] acc_count
);

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t           r_state;
  entry_t           r_or;
  entry_t           r_sr;
  entry_t           w_dec;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_acc;
  logic [31:0]      w_imm32;
  logic [2:0]       w_fmt;
  logic             w_accept;
  logic             w_take;

  // Every format sign-extends from instr[31], so build 32 bits then widen.
  always_comb begin
    w_imm32 = '0;
    w_fmt   = FMT_NONE;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
        w_fmt   = FMT_I;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        w_fmt   = FMT_S;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        w_fmt   = FMT_B;
        w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_fmt   = FMT_U;
        w_imm32 = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        w_fmt   = FMT_J;
        w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign w_dec    = {XLEN'($signed(w_imm32)), w_fmt, (w_fmt == FMT_NONE)};
  assign w_accept = in_valid & r_in_ready;
  assign w_take   = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_or        <= '0;
      r_sr        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
    end else begin
      if (w_accept) r_acc <= r_acc + CNT_W'(1);
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_or        <= w_dec;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_take) begin
            r_or <= w_dec;
          end else if (w_accept) begin
            r_sr       <= w_dec;
            r_in_ready <= 1'b0;
            r_state    <= S_TWO;
          end else if (w_take) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end
        end
        S_TWO: begin
          // Input is closed here, so a take only drains the skid entry.
          if (w_take) begin
            r_or       <= r_sr;
            r_in_ready <= 1'b1;
            r_state    <= S_ONE;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_or.imm;
  assign out_fmt     = r_or.fmt;
  assign out_illegal = r_or.illegal;
  assign acc_count   = r_acc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed bench for imm_gen_pipe at XLEN=64/CNT_W=16 and XLEN=32/CNT_W=4
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [63:0] a_out_imm;
  logic [2:0]  a_out_fmt;
  logic [15:0] a_acc;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [31:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [3:0]  b_acc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
    .acc_count(a_acc)
  );

  imm_gen_pipe #(.XLEN(32), .CNT_W(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal),
    .acc_count(b_acc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] imm, input logic [2:0] fmt,
                         input logic ill);
    chk({tag, "_valid"}, a_out_valid, 1'b1);
    chk({tag, "_imm"}, a_out_imm, imm);
    chk({tag, "_fmt"}, a_out_fmt, fmt);
    chk({tag, "_ill"}, a_out_illegal, ill);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0080006F;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", a_out_valid, 1'b0);
    chk("rst_imm", a_out_imm, 64'd0);
    chk("rst_fmt", a_out_fmt, 3'd0);
    chk("rst_ill", a_out_illegal, 1'b0);
    chk("rst_acc", a_acc, 16'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    chk("rst_in_ready", a_in_ready, 1'b1);

    push(32'hFF813083);
    chk_out("ld", 64'hFFFFFFFFFFFFFFF8, 3'd0, 1'b0);
    chk("ld_x32", b_out_imm, 32'hFFFFFFF8);
    push(32'hFE113C23);
    chk_out("sd", 64'hFFFFFFFFFFFFFFF8, 3'd1, 1'b0);
    push(32'hFE000EE3);
    chk_out("beq", 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    push(32'h800000B7);
    chk_out("lui", 64'hFFFFFFFF80000000, 3'd3, 1'b0);
    chk("lui_x32", b_out_imm, 32'h80000000);
    chk("lui_x32_fmt", b_out_fmt, 3'd3);
    push(32'h0080006F);
    chk_out("jal", 64'd8, 3'd4, 1'b0);
    push(32'h0000007F);
    chk_out("illegal", 64'd0, 3'd7, 1'b1);
    push(32'h00500093);
    chk_out("addi", 64'd5, 3'd0, 1'b0);
    chk("acc_7", a_acc, 16'd7);
    @(negedge clk);
    chk("drain_valid", a_out_valid, 1'b0);

    // Fill both entries, then pull reset between edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00500093;
    repeat (2) @(negedge clk);
    chk("fill_in_ready", a_in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", a_out_valid, 1'b0);
    chk("arst_imm", a_out_imm, 64'd0);
    chk("arst_fmt", a_out_fmt, 3'd0);
    chk("arst_acc", a_acc, 16'd0);
    @(negedge clk);
    chk("arst_hold_valid", a_out_valid, 1'b0);
    chk("arst_hold_acc", b_acc, 4'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    chk("arst_in_ready", a_in_ready, 1'b1);

    // Backpressure: A, B, C offered with the consumer stalled.
    in_valid = 1'b1;
    in_instr = 32'hFF813083;
    @(negedge clk);
    chk("bp_a_ready", a_in_ready, 1'b1);
    in_instr = 32'h800000B7;
    @(negedge clk);
    chk("bp_b_ready", a_in_ready, 1'b0);
    in_instr = 32'h0080006F;
    @(negedge clk);
    chk("bp_hold_imm", a_out_imm, 64'hFFFFFFFFFFFFFFF8);
    chk("bp_hold_acc", a_acc, 16'd2);
    out_ready = 1'b1;
    chk_out("bp_a", 64'hFFFFFFFFFFFFFFF8, 3'd0, 1'b0);
    @(negedge clk);
    chk_out("bp_b", 64'hFFFFFFFF80000000, 3'd3, 1'b0);
    chk("bp_b_in_ready", a_in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("bp_c", 64'd8, 3'd4, 1'b0);
    chk("bp_acc", a_acc, 16'd3);
    @(negedge clk);
    chk("bp_empty", a_out_valid, 1'b0);

    // Counter wrap on the CNT_W=4 instance.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00500093;
    repeat (17) @(negedge clk);
    in_valid = 1'b0;
    chk("wrap_acc4", b_acc, 4'd1);
    chk("wrap_acc16", a_acc, 16'd17);
    @(negedge clk);
    chk("wrap_empty", b_out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
